// File: rtl/spi32_arbiter.sv
// spi32_arbiter: round-robin sharing of one 32-bit SPI engine between N_REQ requesters.
// Define SPI32_ARB_TIMEOUT_EN to add the ARM/XFER watchdog limited by TIMEOUT_CYCLES.
module spi32_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    req_ack,
    output logic [31:0]         resp_data,
    output logic                resp_error,
    output logic [2:0]          grant_id,
    output logic                arb_busy,
    output logic                spi_enabled,
    output logic [31:0]         spi_data_in,
    output logic                spi_continue_read,
    input  logic                spi_busy,
    input  logic [31:0]         spi_data_out
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("spi32_arbiter: N_REQ must be 2..8");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("spi32_arbiter: GAP_CYCLES must be 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("spi32_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_XFER,
        ST_DONE,
        ST_GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       rr_ptr;
    logic [2:0]       ptr_next;
    logic [7:0]       gap_cnt;
    logic [N_REQ-1:0] req_rot;
    logic             pick_found;
    logic [2:0]       pick_idx;
    logic [3:0]       pick_sum;
    logic [31:0]      pick_data;
    logic [N_REQ-1:0] ack_onehot;
    logic             timed_out;

`ifdef SPI32_ARB_TIMEOUT_EN
    logic [15:0]      wd_cnt;
    logic             wd_hit;
    logic             timeout_take;
`endif

    assign spi_continue_read = 1'b0;
    assign arb_busy          = (state != ST_IDLE);
    assign ptr_next          = (grant_id == 3'(N_REQ - 1)) ? '0 : grant_id + 3'd1;

    // Rotating a doubled request vector by the pointer turns the wrap-around
    // search into a plain lowest-set-bit search.
    assign req_rot = N_REQ'({req_valid, req_valid} >> rr_ptr);

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!pick_found && req_rot[i]) begin
                pick_found = 1'b1;
                pick_sum   = {1'b0, rr_ptr} + 4'(i);
                if (pick_sum >= 4'(N_REQ)) begin
                    pick_sum = pick_sum - 4'(N_REQ);
                end
                pick_idx = pick_sum[2:0];
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx == 3'(i)) begin
                pick_data = req_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        ack_onehot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            ack_onehot[i] = (grant_id == 3'(i));
        end
    end

    always_comb begin
        state_nxt = state;
`ifdef SPI32_ARB_TIMEOUT_EN
        timeout_take = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (spi_busy) begin
                    state_nxt = ST_XFER;
                end
`ifdef SPI32_ARB_TIMEOUT_EN
                else if (wd_hit) begin
                    state_nxt    = ST_DONE;
                    timeout_take = 1'b1;
                end
`endif
            end
            ST_XFER: begin
                if (!spi_busy) begin
                    state_nxt = ST_DONE;
                end
`ifdef SPI32_ARB_TIMEOUT_EN
                else if (wd_hit) begin
                    state_nxt    = ST_DONE;
                    timeout_take = 1'b1;
                end
`endif
            end
            ST_DONE: state_nxt = ST_GAP;
            ST_GAP: begin
                if (gap_cnt <= 8'd1) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            gap_cnt     <= '0;
            req_ack     <= '0;
            resp_data   <= '0;
            grant_id    <= '0;
            spi_enabled <= 1'b0;
            spi_data_in <= '0;
        end else begin
            state   <= state_nxt;
            req_ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id    <= pick_idx;
                        spi_data_in <= pick_data;
                        spi_enabled <= 1'b1;
                    end
                end
                ST_DONE: begin
                    resp_data   <= timed_out ? '0 : spi_data_out;
                    req_ack     <= ack_onehot;
                    spi_enabled <= 1'b0;
                    rr_ptr      <= ptr_next;
                    gap_cnt     <= 8'(GAP_CYCLES);
                end
                ST_GAP: gap_cnt <= gap_cnt - 8'd1;
                default: ;
            endcase
        end
    end

`ifdef SPI32_ARB_TIMEOUT_EN
    assign wd_hit = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every state change so ARM and XFER are timed separately.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wd_cnt     <= '0;
            timed_out  <= 1'b0;
            resp_error <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                wd_cnt <= '0;
            end else if (state == ST_ARM || state == ST_XFER) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (state_nxt == ST_DONE) begin
                timed_out <= timeout_take;
            end
            if (state == ST_DONE) begin
                resp_error <= timed_out;
            end
        end
    end
`else
    assign timed_out  = 1'b0;
    assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_spi32_arbiter.sv
// Directed bench for spi32_arbiter with a behavioural SPI engine and an ack scoreboard.
module tb_spi32_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned GAP = 2;
    localparam int unsigned TO  = 16;
    localparam int MODE_NORMAL = 0;
    localparam int MODE_SILENT = 1;
    localparam int MODE_STUCK  = 2;

    logic            clk_in    = 1'b0;
    logic            reset_in  = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [32*N-1:0] req_data  = '0;
    logic [N-1:0]    req_ack;
    logic [31:0]     resp_data;
    logic            resp_error;
    logic [2:0]      grant_id;
    logic            arb_busy;
    logic            spi_enabled;
    logic [31:0]     spi_data_in;
    logic            spi_continue_read;
    logic            spi_busy;
    logic [31:0]     spi_data_out;

    spi32_arbiter #(
        .N_REQ          (N),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ack           (req_ack),
        .resp_data         (resp_data),
        .resp_error        (resp_error),
        .grant_id          (grant_id),
        .arb_busy          (arb_busy),
        .spi_enabled       (spi_enabled),
        .spi_data_in       (spi_data_in),
        .spi_continue_read (spi_continue_read),
        .spi_busy          (spi_busy),
        .spi_data_out      (spi_data_out)
    );

    always #5 clk_in = ~clk_in;

    // Engine model: busy one edge after a fresh enable, low again 128 edges later.
    int          eng_mode = MODE_NORMAL;
    logic [31:0] eng_xor  = '0;
    logic        eng_en_q = 1'b0;
    logic        eng_busy = 1'b0;
    logic [31:0] eng_rx   = '0;
    logic [31:0] eng_tx   = '0;
    int          eng_cnt  = 0;

    assign spi_busy     = eng_busy;
    assign spi_data_out = eng_rx;

    always @(posedge clk_in) begin
        eng_en_q <= spi_enabled;
        if (!spi_enabled) begin
            eng_busy <= 1'b0;
            eng_cnt  <= 0;
        end else if (!eng_en_q) begin
            eng_tx   <= spi_data_in;
            eng_busy <= (eng_mode != MODE_SILENT);
            eng_cnt  <= 128;
        end else if (eng_busy && eng_mode == MODE_NORMAL) begin
            if (eng_cnt == 1) begin
                eng_busy <= 1'b0;
                eng_rx   <= eng_tx ^ eng_xor;
            end
            eng_cnt <= eng_cnt - 1;
        end
    end

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] data;
        logic        err;
        logic [31:0] tx;
    } exp_t;

    exp_t sb[$];
    int   low_runs[$];
    int   n_pass    = 0;
    int   n_checks  = 0;
    int   cyc       = 0;
    int   ack_count = 0;
    int   ack_cyc   = 0;
    int   grant_cyc = 0;
    int   low_run   = 0;
    logic gap_armed = 1'b0;
    logic en_prev   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [2:0] id, input logic [31:0] data,
                            input logic err, input logic [31:0] tx);
        sb.push_back({id, data, err, tx});
    endtask

    task automatic wait_acks(input int target, input int budget, input string tag);
        int n = 0;
        while (ack_count < target && n < budget) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        check(tag, ack_count, target);
    endtask

    task automatic wait_enable(input int budget, input string tag);
        int n = 0;
        while (!spi_enabled && n < budget) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        check(tag, 32'(spi_enabled), 32'd1);
    endtask

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    // Ack scoreboard plus grant-time and enable-low-run tracking.
    initial forever begin
        exp_t e;
        @(negedge clk_in);
        if (req_ack !== '0) begin
            if (sb.size() == 0) begin
                check("ack_unexpected", 32'(req_ack), 32'h0);
            end else begin
                e = sb.pop_front();
                check("ack_onehot", 32'(req_ack), 32'd1 << e.id);
                check("ack_grant_id", 32'(grant_id), 32'(e.id));
                check("resp_data", resp_data, e.data);
                check("resp_error", 32'(resp_error), 32'(e.err));
                check("engine_tx", eng_tx, e.tx);
            end
            ack_count++;
            ack_cyc = cyc;
        end
        if (reset_in) begin
            gap_armed = 1'b0;
            low_run   = 0;
        end else begin
            if (spi_enabled && !en_prev) begin
                grant_cyc = cyc;
                if (gap_armed) low_runs.push_back(low_run);
            end
            if (spi_enabled) begin
                gap_armed = 1'b1;
                low_run   = 0;
            end else begin
                low_run++;
            end
        end
        en_prev = spi_enabled;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed hang expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [31:0] dtab [4];
        int          acks;
        dtab[0] = 32'h1111_0000;
        dtab[1] = 32'h2222_0001;
        dtab[2] = 32'h3333_0002;
        dtab[3] = 32'h4444_0003;
        acks    = 0;

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_req_ack", 32'(req_ack), 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_error", 32'(resp_error), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_arb_busy", 32'(arb_busy), 32'h0);
        check("rst_spi_enabled", 32'(spi_enabled), 32'h0);
        check("rst_spi_data_in", spi_data_in, 32'h0);
        check("rst_continue_read", 32'(spi_continue_read), 32'h0);
        reset_in = 1'b0;
        @(posedge clk_in);
        #1;

        // Round robin: all requesters held, expect 0,1,2,3,0.
        eng_xor = 32'h0F0F_F0F0;
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = dtab[i];
        low_runs.delete();
        for (int k = 0; k < 5; k++) begin
            push_exp(3'(k % 4), dtab[k % 4] ^ 32'h0F0F_F0F0, 1'b0, dtab[k % 4]);
        end
        req_valid = 4'b1111;
        acks += 5;
        wait_acks(acks, 1000, "rr_acks");
        req_valid = '0;
        check("rr_gap_count", low_runs.size(), 4);
        for (int k = 0; k < 4; k++) check("rr_gap_low", low_runs[k], GAP + 1);

        // Single request from requester 0.
        repeat (5) @(posedge clk_in);
        #1;
        eng_xor = 32'hA5A5_0F0F ^ 32'h1234_5678;
        req_data[31:0] = 32'hA5A5_0F0F;
        push_exp(3'd0, 32'h1234_5678, 1'b0, 32'hA5A5_0F0F);
        req_valid = 4'b0001;
        acks += 1;
        wait_acks(acks, 300, "single_ack");
        check("single_latency", ack_cyc - grant_cyc, 131);
        req_valid = '0;
        repeat (20) @(posedge clk_in);
        #1;
        check("single_one_ack", ack_count, acks);
        check("single_resp_hold", resp_data, 32'h1234_5678);
        check("single_tx_hold", spi_data_in, 32'hA5A5_0F0F);
        check("single_idle", 32'(arb_busy), 32'h0);

        // Fairness: grant 2 alone, then 0101 must go to 0 before 2.
        eng_xor = 32'h5A5A_5A5A;
        push_exp(3'd2, dtab[2] ^ 32'h5A5A_5A5A, 1'b0, dtab[2]);
        req_valid = 4'b0100;
        acks += 1;
        wait_acks(acks, 300, "fair_first");
        push_exp(3'd0, dtab[0] ^ 32'h5A5A_5A5A, 1'b0, dtab[0]);
        push_exp(3'd2, dtab[2] ^ 32'h5A5A_5A5A, 1'b0, dtab[2]);
        req_data[31:0] = dtab[0];
        req_valid = 4'b0101;
        acks += 1;
        wait_acks(acks, 300, "fair_wrap");
        req_valid = 4'b0100;
        acks += 1;
        wait_acks(acks, 300, "fair_second");
        req_valid = '0;
        repeat (5) @(posedge clk_in);
        #1;

        // Reset 40 cycles into a transfer of requester 3; pointer must return to 0.
        req_valid = 4'b1000;
        wait_enable(20, "rst_grant_seen");
        repeat (40) @(posedge clk_in);
        #1;
        check("rst_mid_busy", 32'(arb_busy), 32'h1);
        req_valid = 4'b1010;
        reset_in  = 1'b1;
        #1;
        check("rst_mid_enabled", 32'(spi_enabled), 32'h0);
        check("rst_mid_req_ack", 32'(req_ack), 32'h0);
        check("rst_mid_arb_busy", 32'(arb_busy), 32'h0);
        check("rst_mid_grant_id", 32'(grant_id), 32'h0);
        check("rst_mid_resp_data", resp_data, 32'h0);
        check("rst_mid_data_in", spi_data_in, 32'h0);
        @(posedge clk_in);
        #1;
        check("rst_mid_no_ack", ack_count, acks);
        push_exp(3'd1, dtab[1] ^ 32'h5A5A_5A5A, 1'b0, dtab[1]);
        push_exp(3'd3, dtab[3] ^ 32'h5A5A_5A5A, 1'b0, dtab[3]);
        reset_in = 1'b0;
        acks += 1;
        wait_acks(acks, 300, "rst_after_low");
        req_valid = 4'b1000;
        acks += 1;
        wait_acks(acks, 300, "rst_after_next");
        req_valid = '0;
        repeat (5) @(posedge clk_in);
        #1;

`ifdef SPI32_ARB_TIMEOUT_EN
        // Silent engine: watchdog fires in ARM.
        eng_mode = MODE_SILENT;
        push_exp(3'd0, 32'h0, 1'b1, dtab[0]);
        req_valid = 4'b0001;
        acks += 1;
        wait_acks(acks, 100, "to_arm_ack");
        check("to_arm_latency", ack_cyc - grant_cyc, TO + 1);
        req_valid = '0;
        repeat (5) @(posedge clk_in);
        #1;

        // Stuck busy on requester 1: watchdog fires in XFER, then requester 0 is served.
        eng_mode = MODE_STUCK;
        push_exp(3'd1, 32'h0, 1'b1, dtab[1]);
        push_exp(3'd0, dtab[0] ^ 32'h5A5A_5A5A, 1'b0, dtab[0]);
        req_valid = 4'b0011;
        acks += 1;
        wait_acks(acks, 100, "to_xfer_ack");
        check("to_xfer_latency", ack_cyc - grant_cyc, TO + 3);
        eng_mode  = MODE_NORMAL;
        req_valid = 4'b0001;
        acks += 1;
        wait_acks(acks, 300, "to_next_served");
        req_valid = '0;
        repeat (5) @(posedge clk_in);
        #1;
`endif

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
